// File: rtl/move_input_ctrl_pkg.sv
// Shared definitions for the tic-tac-toe move input path: cell codes, grid
// geometry, FSM encoding, button indices and cursor helpers.
package move_input_ctrl_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  localparam int NUM_CELLS = 9;
  localparam int GRID_W    = 3;
  localparam int BOARD_W   = 2 * NUM_CELLS;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_CONFIRM = 4;
  localparam int NUM_BTNS    = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Enumeration order mirrors the arbitration order: Up > Down > Left > Right.
  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

  // Moves one step in the requested direction, saturating at the board edge.
  function automatic logic [3:0] step_cursor(input logic [3:0] cur, input dir_t dir);
    logic [3:0] r;
    logic [3:0] c;
    r = cur / 4'(GRID_W);
    c = cur % 4'(GRID_W);
    case (dir)
      DIR_UP:    if (r != 4'd0)              r = r - 4'd1;
      DIR_DOWN:  if (r != 4'(GRID_W - 1))    r = r + 4'd1;
      DIR_LEFT:  if (c != 4'd0)              c = c - 4'd1;
      DIR_RIGHT: if (c != 4'(GRID_W - 1))    c = c + 4'd1;
      default:   ;
    endcase
    return r * 4'(GRID_W) + c;
  endfunction

  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) v = b[2*i +: 2];
    end
    return v;
  endfunction

endpackage

// File: rtl/move_input_ctrl_button_debounce.sv
// One raw button: 2-flop synchroniser, stability-counter debounce and a
// registered single-cycle press pulse on the debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      press   <= level & ~level_d;
      // Any return to the current debounced level restarts the stability window.
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Debounces the five player buttons, tracks the 3x3 cursor and offers one
// validated move per confirm press to the board/turn controller.
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_confirm,
  input  logic [BOARD_W-1:0] board,
  input  logic [1:0]         turn,
  input  logic               game_over,
  input  logic               move_ready,
  output logic               move_valid,
  output logic [3:0]         move_addr,
  output logic [1:0]         move_value,
  output logic [3:0]         cursor,
  output logic               reject
);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] lvl;
  logic [NUM_BTNS-1:0] prs;
  state_t              state;
  dir_t                dir;
  logic                occupied;
  logic                turn_ok;

  assign raw_btn[BTN_UP]      = btn_up;
  assign raw_btn[BTN_DOWN]    = btn_down;
  assign raw_btn[BTN_LEFT]    = btn_left;
  assign raw_btn[BTN_RIGHT]   = btn_right;
  assign raw_btn[BTN_CONFIRM] = btn_confirm;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[g]),
      .level(lvl[g]),
      .press(prs[g])
    );
  end

  assign dir      = pick_dir(prs[BTN_UP], prs[BTN_DOWN], prs[BTN_LEFT], prs[BTN_RIGHT]);
  assign occupied = (cell_at(board, cursor) != CELL_EMPTY);
  assign turn_ok  = (turn == CELL_P1) || (turn == CELL_P2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cursor     <= 4'd0;
      move_valid <= 1'b0;
      move_addr  <= 4'd0;
      move_value <= 2'd0;
      reject     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The confirm below sees the pre-move cursor; the step lands next cycle.
          cursor <= step_cursor(cursor, dir);
          if (prs[BTN_CONFIRM] && !game_over) begin
            if (occupied || !turn_ok) begin
              reject <= 1'b1;
            end else begin
              state      <= ST_OFFER;
              move_valid <= 1'b1;
              move_addr  <= cursor;
              move_value <= turn;
            end
          end
        end
        ST_OFFER: begin
          if (game_over) begin
            move_valid <= 1'b0;
            state      <= ST_IDLE;
          end else if (move_ready) begin
            move_valid <= 1'b0;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!lvl[BTN_CONFIRM]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with a 4-cycle debounce window.
module tb_move_input_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_confirm;
  logic [17:0] board;
  logic [1:0]  turn;
  logic        game_over;
  logic        move_ready;
  logic        move_valid;
  logic [3:0]  move_addr;
  logic [1:0]  move_value;
  logic [3:0]  cursor;
  logic        reject;

  int checks = 0;
  int errors = 0;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_confirm(btn_confirm),
    .board      (board),
    .turn       (turn),
    .game_over  (game_over),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_addr  (move_addr),
    .move_value (move_value),
    .cursor     (cursor),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_dir(input int b, input logic v);
    case (b)
      B_UP:    btn_up    = v;
      B_DOWN:  btn_down  = v;
      B_LEFT:  btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press_dir(input int b);
    set_dir(b, 1'b1);
    tick(10);
    set_dir(b, 1'b0);
    tick(10);
  endtask

  initial begin
    reset = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_confirm = 0;
    board = '0; turn = 2'd1; game_over = 0; move_ready = 0;
    tick(3);
    check("rst_cursor", cursor, 0);
    check("rst_valid", move_valid, 0);
    check("rst_addr", move_addr, 0);
    check("rst_value", move_value, 0);
    check("rst_reject", reject, 0);

    // 1: held right -> press after 2+4+1 edges, cursor updates one edge later
    reset = 1'b0;
    btn_right = 1'b1;
    tick(7);
    check("right_latency_before", cursor, 0);
    tick(1);
    check("right_latency_after", cursor, 1);
    tick(12);
    check("right_held_single", cursor, 1);
    btn_right = 1'b0;
    tick(10);
    check("right_release_nopulse", cursor, 1);
    btn_right = 1'b1;
    tick(3);
    btn_right = 1'b0;
    tick(12);
    check("right_glitch", cursor, 1);

    // 2: navigation with saturation and priority
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("nav_start", cursor, 0);
    press_dir(B_DOWN);  check("nav_down1", cursor, 3);
    press_dir(B_DOWN);  check("nav_down2", cursor, 6);
    press_dir(B_RIGHT); check("nav_right1", cursor, 7);
    press_dir(B_RIGHT); check("nav_right2", cursor, 8);
    press_dir(B_RIGHT); check("nav_right_sat", cursor, 8);
    btn_up = 1'b1; btn_left = 1'b1;
    tick(10);
    btn_up = 1'b0; btn_left = 1'b0;
    tick(10);
    check("nav_up_left_prio", cursor, 5);

    // 3: offer, hold, handshake, no double load
    press_dir(B_LEFT);
    check("nav_left", cursor, 4);
    btn_confirm = 1'b1;
    tick(7);
    check("offer_before", move_valid, 0);
    tick(1);
    check("offer_valid", move_valid, 1);
    check("offer_addr", move_addr, 4);
    check("offer_value", move_value, 1);
    tick(10);
    check("offer_hold_valid", move_valid, 1);
    check("offer_hold_addr", move_addr, 4);
    move_ready = 1'b1;
    tick(1);
    check("handshake_drop", move_valid, 0);
    move_ready = 1'b0;
    btn_confirm = 1'b0;
    tick(3);
    btn_confirm = 1'b1;
    tick(12);
    check("release_no_reload", move_valid, 0);
    check("release_addr_kept", move_addr, 4);
    btn_confirm = 1'b0;
    tick(12);
    btn_confirm = 1'b1;
    tick(8);
    check("repress_valid", move_valid, 1);
    check("repress_addr", move_addr, 4);
    move_ready = 1'b1;
    tick(1);
    check("repress_drop", move_valid, 0);
    move_ready = 1'b0;
    btn_confirm = 1'b0;
    tick(12);

    // 4: occupied cell and invalid turn are rejected
    board = 18'd0;
    board[9:8] = 2'd2;
    btn_confirm = 1'b1;
    tick(8);
    check("occ_reject", reject, 1);
    check("occ_no_valid", move_valid, 0);
    tick(1);
    check("occ_reject_1cyc", reject, 0);
    check("occ_no_valid2", move_valid, 0);
    btn_confirm = 1'b0;
    tick(12);
    board = '0;
    turn = 2'd0;
    btn_confirm = 1'b1;
    tick(8);
    check("turn0_reject", reject, 1);
    tick(1);
    check("turn0_reject_1cyc", reject, 0);
    check("turn0_no_valid", move_valid, 0);
    btn_confirm = 1'b0;
    tick(12);
    turn = 2'd1;

    // 5: game over suppresses moves and cancels an open offer
    game_over = 1'b1;
    btn_confirm = 1'b1;
    tick(8);
    check("go_no_valid", move_valid, 0);
    check("go_no_reject", reject, 0);
    tick(1);
    check("go_no_valid2", move_valid, 0);
    check("go_no_reject2", reject, 0);
    btn_confirm = 1'b0;
    tick(12);
    game_over = 1'b0;
    btn_confirm = 1'b1;
    tick(8);
    check("go_offer_valid", move_valid, 1);
    game_over = 1'b1;
    move_ready = 1'b1;
    tick(1);
    check("go_cancel", move_valid, 0);
    check("go_cancel_reject", reject, 0);
    tick(5);
    check("go_stays_idle", move_valid, 0);
    game_over = 1'b0;
    move_ready = 1'b0;
    btn_confirm = 1'b0;
    tick(12);

    // 6: asynchronous reset during an offer
    press_dir(B_DOWN);
    check("pre_async_cursor", cursor, 7);
    btn_confirm = 1'b1;
    tick(8);
    check("pre_async_valid", move_valid, 1);
    check("pre_async_addr", move_addr, 7);
    #3;
    reset = 1'b1;
    btn_confirm = 1'b0;
    #1;
    check("async_valid", move_valid, 0);
    check("async_cursor", cursor, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("async_addr", move_addr, 0);
    press_dir(B_RIGHT);
    check("post_reset_cursor", cursor, 1);
    btn_confirm = 1'b1;
    tick(8);
    check("post_reset_valid", move_valid, 1);
    check("post_reset_addr", move_addr, 1);
    check("post_reset_value", move_value, 1);
    move_ready = 1'b1;
    tick(1);
    check("post_reset_drop", move_valid, 0);
    move_ready = 1'b0;
    btn_confirm = 1'b0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
